edge_event_arbiter: RTL and testbench
=====================================

// Module: edge_event_arbiter
// PURPOSE
//  Detects rising edges on N_CH independent single-bit inputs and queues one pending event per channel.
//  Serialises pending events onto one valid/ready event port using round-robin arbitration.
//  Lets several edge sources share one downstream event consumer, e.g. an interrupt or status handler.
// PARAMETERS
//  N_CH   4                  number of input channels (2..32)
//  ID_W   $clog2(N_CH)       width of evt_id (derived, not overridden)
// PORTS
//  clk          in   1      clock; all logic on posedge
//  resetn       in   1      synchronous, active-low reset
//  din          in   N_CH   level inputs, one per channel, already synchronous to clk
//  evt_valid    out  1      event presented
//  evt_ready    in   1      consumer accepts the event when evt_valid & evt_ready
//  evt_id       out  ID_W   channel number of the presented event
//  pending      out  N_CH   registered per-channel pending bits (status)
//  ovf          out  N_CH   sticky per-channel overflow flags (see CONFIGURATION)
//  ovf_clr      in   N_CH   write-1-to-clear pulses for ovf
// BEHAVIOUR
//  Reset (resetn=0 at posedge):
//   - prev, pending, ovf all 0; evt_valid=0; evt_id=0; RR pointer=0; FSM=IDLE.
//   - din is treated as 0 while in reset, so din=1 on the first cycle after release counts as an edge.
//  Edge detect:
//   - edge[i] = din[i] & ~prev[i]; prev <= din every non-reset cycle.
//  Pending set/clear:
//   - edge[i] sets pending[i] at the same posedge.
//   - A grant clears pending[i] at the posedge where the event is loaded onto the output.
//   - If a grant and a new edge hit the same channel in one cycle, the set wins: pending stays 1.
//  Overflow:
//   - edge[i] while pending[i]=1 and channel i is not granted that cycle: event lost, pending stays 1.
//   - In that case ovf[i] is set when enabled.
//  FSM states: IDLE, PRESENT.
//   - IDLE: if |pending, load the RR winner into evt_id, set evt_valid=1, clear its pending bit, go to PRESENT.
//   - IDLE: otherwise stay in IDLE.
//   - PRESENT: evt_valid and evt_id are held stable until evt_ready.
//   - PRESENT, on handshake: if |pending (evaluated before this cycle's sets), load the next winner in the same cycle (back-to-back, no bubble).
//   - PRESENT, on handshake with nothing pending: evt_valid=0, go to IDLE.
//  Round robin:
//   - Search starts at ptr and wraps modulo N_CH.
//   - After granting channel k, ptr <= (k+1) mod N_CH; at k=N_CH-1 it wraps to 0.
//  Latency: din rising sampled at posedge t -> pending at t -> evt_valid=1 after posedge t+1 (FSM idle, no contention).
//  Throughput: one event per cycle while evt_ready is held 1.
//  Reset mid-operation: the presented event and all pending events are discarded without handshake.
// CONFIGURATION
//  Macro EDGE_ARB_OVF_EN
//   - Defined: ovf[i] is set on overflow.
//   - Defined: ovf_clr[i]=1 clears ovf[i] next posedge; set and clear in the same cycle -> set wins.
//   - Undefined: ovf is tied to 0, ovf_clr is ignored, no overflow registers are built.
//  Port list is identical in both builds.
// STRUCTURE
//  Package edge_arb_pkg:
//   - typedef enum logic {IDLE, PRESENT} arb_state_t
//   - localparam N_CH_DEFAULT = 4
//   - function rr_next(ptr, N) for pointer wrap
//  Sub-module edge_arb_rr_pick (combinational):
//   - inputs: req[N_CH], ptr[ID_W]
//   - outputs: gnt_vld, gnt_id[ID_W]
//   - fixed-priority search over the request vector rotated by ptr
//  Top holds prev/pending/ovf regs, the FSM and the output registers.
// TESTING
//  1. Reset: hold resetn=0 with din=4'b1111 -> evt_valid=0, pending=0. Release -> pending=4'b1111 after the 1st posedge; ids 0,1,2,3 in order with evt_ready=1.
//  2. Single edge: din[2] 0->1 and held, evt_ready=1 -> one event id=2 two cycles later; no repeat while din[2] stays high.
//  3. Backpressure: edge on ch1, evt_ready=0 for 5 cycles -> evt_valid and evt_id=1 stable for 5 cycles; accepted on the 6th; then evt_valid=0.
//  4. Fairness: edges on ch3 and ch0 in the same cycle with ptr=2 -> grant order 3, then 0; ptr ends at 1.
//  5. Overflow (EDGE_ARB_OVF_EN): evt_ready=0, two edges on ch0 -> ovf[0]=1, only one ch0 event delivered; ovf_clr[0] pulse -> ovf[0]=0. Without the macro ovf stays 0.
//  6. Reset mid-operation: resetn=0 while evt_valid=1 with 2 pending -> all cleared next posedge; no events after release if din is low.

Source files
------------

// File: rtl/edge_arb_pkg.sv
// Shared types and helpers for the edge event arbiter.
package edge_arb_pkg;

  typedef enum logic {IDLE, PRESENT} arb_state_t;

  localparam int N_CH_DEFAULT = 4;

  // Round-robin pointer successor, wrapping at n-1 back to 0.
  function automatic logic [31:0] rr_next(input logic [31:0] ptr, input int unsigned n);
    return (ptr >= n - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/edge_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module edge_arb_rr_pick
  import edge_arb_pkg::*;
#(
  parameter  int N_CH = N_CH_DEFAULT,
  localparam int ID_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            gnt_vld,
  output logic [ID_W-1:0] gnt_id
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [ID_W:0]     sum;

  // Duplicating the vector turns the modulo rotation into a plain shift.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_CH-1:0];

  always_comb begin
    gnt_vld = 1'b0;
    sum     = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (rot[j]) begin
        gnt_vld = 1'b1;
        sum     = {1'b0, ptr} + (ID_W+1)'(j);
      end
    end
    if (sum >= (ID_W+1)'(N_CH)) sum = sum - (ID_W+1)'(N_CH);
    gnt_id = sum[ID_W-1:0];
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge detector with per-channel pending bits, serialised round-robin onto a valid/ready port.
// Define EDGE_ARB_OVF_EN to build the sticky per-channel overflow flags.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int N_CH = N_CH_DEFAULT,
  localparam int ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N_CH-1:0] din,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] ovf,
  input  logic [N_CH-1:0] ovf_clr
);

  arb_state_t      state;
  logic [N_CH-1:0] prev, edge_v, clr, pend_nxt;
  logic [ID_W-1:0] ptr, gnt_id;
  logic            gnt_vld, take;

  edge_arb_rr_pick #(.N_CH(N_CH)) u_pick (
    .req     (pending),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // In PRESENT the output slot frees only on handshake; IDLE always has room.
  assign take     = gnt_vld & ((state == IDLE) | evt_ready);
  assign clr      = take ? (N_CH'(1) << gnt_id) : '0;
  assign edge_v   = din & ~prev;
  assign pend_nxt = (pending & ~clr) | edge_v;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev      <= '0;
      pending   <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      ptr       <= '0;
      state     <= IDLE;
    end else begin
      prev    <= din;
      pending <= pend_nxt;
      case (state)
        IDLE: begin
          if (take) begin
            evt_valid <= 1'b1;
            evt_id    <= gnt_id;
            ptr       <= ID_W'(rr_next(32'(gnt_id), N_CH));
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (take) begin
            evt_id <= gnt_id;
            ptr    <= ID_W'(rr_next(32'(gnt_id), N_CH));
          end else if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EDGE_ARB_OVF_EN
  logic [N_CH-1:0] ovf_q, lost;

  // An edge on a still-pending channel that is not being granted is dropped.
  assign lost = edge_v & pending & ~clr;

  always_ff @(posedge clk) begin
    if (!resetn) ovf_q <= '0;
    else         ovf_q <= (ovf_q & ~ovf_clr) | lost;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ^ovf_clr;
  assign ovf            = '0;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: expected ids queued at stimulus, popped on handshake.
module tb_edge_event_arbiter;

  localparam int N_CH = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N_CH-1:0] din;
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] ovf;
  logic [N_CH-1:0] ovf_clr;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  edge_event_arbiter #(.N_CH(N_CH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .din       (din),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !evt_valid) break;
      tick();
    end
    chk("drain_q", exp_q.size(), 0);
    chk("drain_valid", evt_valid, 0);
  endtask

  // Handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) chk("unexpected_evt", {30'd0, evt_id}, 32'hdead);
      else                   chk("evt_id", {30'd0, evt_id}, exp_q.pop_front());
    end
  end

  initial begin
    int n;
    resetn = 1'b0; din = '0; evt_ready = 1'b0; ovf_clr = '0;

    // 1: reset with all inputs high, then release
    din = 4'b1111;
    tick(3);
    chk("rst_valid", evt_valid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ovf", ovf, 0);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    resetn = 1'b1; evt_ready = 1'b1;
    tick();
    chk("rel_pending", pending, 4'b1111);
    chk("rel_valid", evt_valid, 0);
    drain();
    chk("t1_pending", pending, 0);
    din = '0; tick(2);

    // 2: single edge, latency, no repeat while held
    exp_q.push_back(2);
    din = 4'b0100;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); n++;
      if (evt_valid) break;
    end
    chk("t2_latency", n, 2);
    chk("t2_id", evt_id, 2);
    tick(10);
    chk("t2_norepeat_q", exp_q.size(), 0);
    chk("t2_norepeat_v", evt_valid, 0);
    din = '0; tick(2);

    // 3: backpressure on ch1
    evt_ready = 1'b0;
    exp_q.push_back(1);
    din = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      if (evt_valid) break;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_v", evt_valid, 1);
      chk("t3_hold_id", evt_id, 1);
      tick();
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("t3_after_v", evt_valid, 0);
    chk("t3_q", exp_q.size(), 0);
    din = '0; tick(2);

    // 4: fairness from ptr=2, then confirm ptr landed on 1
    evt_ready = 1'b1;
    exp_q.push_back(3); exp_q.push_back(0);
    din = 4'b1001;
    drain();
    din = '0; tick(2);
    exp_q.push_back(1); exp_q.push_back(0);
    din = 4'b0011;
    drain();
    din = '0; tick(2);

    // 5: overflow on ch0 while output is held by ch1
    evt_ready = 1'b0;
    exp_q.push_back(1); exp_q.push_back(0);
    din = 4'b0010; tick(3);
    chk("t5_busy", evt_valid, 1);
    din = 4'b0011; tick();
    din = 4'b0010; tick();
    din = 4'b0011; tick();
    chk("t5_pending", pending, 4'b0001);
`ifdef EDGE_ARB_OVF_EN
    chk("t5_ovf_set", ovf, 4'b0001);
`else
    chk("t5_ovf_off", ovf, 0);
`endif
    ovf_clr = 4'b0001; tick();
    ovf_clr = '0;
    chk("t5_ovf_clr", ovf, 0);
    din = '0; evt_ready = 1'b1;
    drain();
    tick(2);

    // 6: reset while presenting with two pending
    evt_ready = 1'b0;
    din = 4'b0111; tick(4);
    chk("t6_valid", evt_valid, 1);
    chk("t6_npend", $countones(pending), 2);
    resetn = 1'b0; din = '0; tick();
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_pending", pending, 0);
    resetn = 1'b1; evt_ready = 1'b1;
    tick(10);
    chk("t6_quiet", evt_valid, 0);
    chk("t6_q", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
